// File: rtl/fsm_round_monitor.sv
// Per-round ctl-high cycle counter with indexed result FIFO and sticky overflow flag.
// Define FSM_ROUND_MONITOR_TIMEOUT_EN to add the done-watchdog driving the timeout flag.
module fsm_round_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned DEPTH = 4
`ifdef FSM_ROUND_MONITOR_TIMEOUT_EN
  ,
  parameter int unsigned TO_W  = 10
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctl,
  input  logic             done,
  input  logic             clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cnt,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_sat,
  output logic             ovf,
  output logic             timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] mem_cnt_q [DEPTH];
  logic [IDX_W-1:0] mem_idx_q [DEPTH];
  logic             mem_sat_q [DEPTH];

  logic             acc_at_max;
  logic [CNT_W-1:0] cap_cnt;
  logic             cap_sat;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;

  // Closing count folds in the done-cycle ctl, clipped at the counter maximum.
  always_comb begin
    acc_at_max = (acc_q == CntMax);
    cap_cnt    = acc_at_max ? acc_q : acc_q + CNT_W'(ctl);
    cap_sat    = sat_q | (acc_at_max & ctl);
  end

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = ~fifo_empty & res_ready;
    // A pop in the same cycle frees the slot the push needs.
    push       = done & (~fifo_full | pop);
  end

  always_comb begin
    acc_d    = acc_q;
    sat_d    = sat_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    if (done) begin
      acc_d = '0;
      sat_d = 1'b0;
      idx_d = idx_q + IDX_W'(1);
    end else if (ctl) begin
      if (acc_at_max) begin
        sat_d = 1'b1;
      end else begin
        acc_d = acc_q + CNT_W'(1);
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (done && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_cnt_q[wr_ptr_q[AW-1:0]] <= cap_cnt;
      mem_idx_q[wr_ptr_q[AW-1:0]] <= idx_q;
      mem_sat_q[wr_ptr_q[AW-1:0]] <= cap_sat;
    end
  end

  always_comb begin
    res_valid = ~fifo_empty;
    res_cnt   = res_valid ? mem_cnt_q[rd_ptr_q[AW-1:0]] : '0;
    res_idx   = res_valid ? mem_idx_q[rd_ptr_q[AW-1:0]] : '0;
    res_sat   = res_valid ? mem_sat_q[rd_ptr_q[AW-1:0]] : 1'b0;
    ovf       = ovf_q;
  end

`ifdef FSM_ROUND_MONITOR_TIMEOUT_EN
  localparam logic [TO_W-1:0] ToMax = {TO_W{1'b1}};

  logic [TO_W-1:0] wd_q, wd_d;
  logic            timeout_q;

  // Watchdog restarts on every round end and parks at its maximum.
  always_comb begin
    wd_d = wd_q;
    if (done) begin
      wd_d = '0;
    end else if (wd_q != ToMax) begin
      wd_d = wd_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (clr) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == ToMax) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/fsm_round_monitor.md
Name: fsm_round_monitor

Overview:
- Sits directly downstream of the IDLE/GO/DONE sequencer FSM and consumes its ctl and done outputs.
- Per round (interval closed by a done pulse), counts the cycles ctl was high.
- Tags each count with a round index and queues it in a small FIFO.
- Presents queued results to a consumer over a valid/ready interface; FIFO overflow and counter saturation are reported as sticky flags.

Parameters:
- CNT_W, 8: width of the per-round ctl-high counter.
- IDX_W, 4: width of the round index; wraps modulo 2^IDX_W.
- DEPTH, 4: result FIFO depth; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ctl  input  1  control level from the sequencer FSM.
- done  input  1  round-complete indication from the sequencer FSM; each high cycle is one round end.
- clr  input  1  synchronous clear of all state.
- res_valid  output  1  FIFO head is valid.
- res_ready  input  1  consumer accepts the head.
- res_cnt  output  CNT_W  ctl-high cycle count of the head round.
- res_idx  output  IDX_W  round index of the head round.
- res_sat  output  1  head count saturated.
- ovf  output  1  sticky flag: a round result was dropped.
- timeout  output  1  sticky flag; see Optional Feature.

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset and clr:
  - All outputs reset to 0. Accumulator, round index and FIFO pointers reset to 0; FIFO empty.
  - clr clears the same state on the next edge. clr has priority over done, ctl and pops in the same cycle.
- Accumulator:
  - acc increments each cycle ctl=1.
  - Saturates at 2^CNT_W-1 and sets the internal sat bit; no wrap.
- Round close (done=1):
  - Captured count = acc + ctl (same-cycle ctl included), saturated.
  - Captured sat = sat bit OR saturation on this add.
  - Next cycle: acc=0 and sat=0. If ctl=1 in the done cycle, it is counted in the closing round only.
  - Round index captured = current idx; idx then increments, wrapping 2^IDX_W-1 -> 0.
  - idx increments even when the result is dropped; gaps in res_idx expose drops.
- Consecutive done cycles close consecutive rounds. A round may have count 0.
- FIFO push:
  - Push on done when not full.
  - If full and a pop occurs in the same cycle (res_valid & res_ready), the push is accepted.
  - If full with no pop: the result is dropped and ovf is set; ovf stays set until clr or reset.
- FIFO pop: on res_valid & res_ready. The head advances the next cycle.
- Output timing:
  - res_* are driven from the registered FIFO head; no combinational path from done/ctl to the outputs.
  - Latency: done in cycle N -> res_valid=1 and data visible in cycle N+1 (FIFO previously empty).
- Output stability: res_cnt, res_idx and res_sat are stable while res_valid=1 and res_ready=0.
- Simultaneous push and pop on an empty FIFO cannot occur, since res_valid=0. On a non-empty, non-full FIFO, occupancy is unchanged.
- res_ready while res_valid=0 is ignored.
- ctl/done are sampled as synchronous inputs in the clk domain; no synchronizers.

Optional Feature:
- Macro: FSM_ROUND_MONITOR_TIMEOUT_EN.
- Enabled:
  - Adds parameter TO_W (default 10) and a free-running watchdog counter.
  - The counter clears on done or clr and increments otherwise.
  - When it reaches 2^TO_W-1, timeout sets (sticky until clr or reset) and the counter holds.
- Disabled: timeout is tied to 0 and no watchdog logic exists.
- The port list is identical in both builds.

Test Plan:
- Reset release, ctl=0, done=0 for 10 cycles -> res_valid=0, ovf=0, timeout=0, all res_* = 0.
- Drive from the sequencer FSM (ctl high in GO and DONE, done in DONE), res_ready=1 -> results cnt=2, idx 0,1,2,...,15,0; sat=0; ovf=0.
- CNT_W=3: ctl=1 for 12 cycles, then done with ctl=1 -> res_cnt=7, res_sat=1. Next round: ctl=1 for 2 cycles, then done with ctl=0 -> cnt=2, sat=0.
- res_ready=0, 5 done pulses with ctl=0 between:
  - FIFO holds idx 0..3.
  - 5th pulse dropped; ovf=1.
  - Then res_ready=1 -> idx 0,1,2,3 drained, res_valid=0.
  - Next round reports idx 5.
- FIFO full: done coincident with res_ready=1 -> push accepted, ovf stays 0, occupancy stays 4. clr asserted with done -> FIFO empty, idx=0, ovf=0 next cycle.
- With FSM_ROUND_MONITOR_TIMEOUT_EN and TO_W=4: no done for 15 cycles -> timeout=1 and stays 1 after a later done; clr -> timeout=0. Without the macro -> timeout=0 throughout.
